// File: rtl/pam_stream_scanner.sv
// pam_stream_scanner
//
// Streaming PAM-motif detector. Nucleotides arrive one per handshake as 2-bit
// codes (A=00 C=01 G=10 T=11). The last PAM_LEN accepted bases are held in a
// window and compared against a programmable pattern with a don't-care mask.
// The compare runs on the forward strand and, optionally, on the
// reverse-complement strand. Each hit is pushed into a small result FIFO as
// {fwd_hit, rev_hit, position}. The AXI4-Lite register block drains that FIFO.
//
// Ports
//   clock, reset   single rising-edge clock; asynchronous active-high reset
//   cfg_pattern    base i at [2i+1:2i]
//   cfg_mask       bit i = 1 makes base i a don't-care
//   cfg_seq_len    number of bases to scan (0 = finish immediately)
//   cfg_rc_en      also search the reverse-complement pattern
//   start          one-cycle pulse; honoured only in IDLE or DONE
//   in_base/in_valid/in_ready   nucleotide stream
//   res_data/res_valid/res_ready  result FIFO head and pop handshake
//   match_count    hits pushed during the current scan (saturating)
//   busy           scanning or draining
//   done           scan finished and the FIFO has emptied
module pam_stream_scanner #(
  parameter int PAM_LEN    = 3,
  parameter int POS_W      = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2*PAM_LEN-1:0]   cfg_pattern,
  input  logic [PAM_LEN-1:0]     cfg_mask,
  input  logic [POS_W-1:0]       cfg_seq_len,
  input  logic                   cfg_rc_en,
  input  logic                   start,
  input  logic [1:0]             in_base,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [POS_W+1:0]       res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [POS_W-1:0]       match_count,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = POS_W + 2;

  localparam logic [POS_W-1:0] LP_POS_ONE = POS_W'(1);
  localparam logic [POS_W-1:0] LP_K0      = POS_W'(PAM_LEN - 1);
  localparam logic [AW-1:0]    LP_PTR_ONE = AW'(1);
  localparam logic [AW:0]      LP_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]      LP_CNT_MAX = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [2*PAM_LEN-1:0]   r_pat;
  logic [PAM_LEN-1:0]     r_mask;
  logic [POS_W-1:0]       r_len;
  logic                   r_rc;
  logic [POS_W-1:0]       r_pos;        // index k of the next base to accept
  logic [1:0]             r_win [PAM_LEN];
  logic [POS_W-1:0]       r_mc;

  logic [RW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [AW:0]            r_cnt;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_last;
  logic                   w_armed;
  logic                   w_fwd;
  logic                   w_rev;
  logic [1:0]             w_cand [PAM_LEN];
  logic [RW-1:0]          w_rec;

  assign w_full    = (r_cnt == LP_CNT_MAX);
  assign w_empty   = (r_cnt == '0);
  // in_ready drops as soon as the FIFO is full, so a hit on an accepted base
  // always has a free slot and nothing is ever dropped.
  assign in_ready  = (r_state == S_SCAN) && !w_full;
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = !w_empty && res_ready;
  assign w_armed   = (r_pos >= LP_K0);
  assign w_last    = ((r_pos + LP_POS_ONE) == r_len);

  // The candidate window is the window as it will look after this accept.
  always_comb begin
    for (int i = 0; i < PAM_LEN - 1; i++) begin
      w_cand[i] = r_win[i+1];
    end
    w_cand[PAM_LEN-1] = in_base;
  end

  // The reverse-complement pattern is the pattern reversed with each base
  // inverted. In this 2-bit code, inverting a base complements it (A<->T, C<->G).
  always_comb begin
    w_fwd = 1'b1;
    w_rev = r_rc;
    for (int i = 0; i < PAM_LEN; i++) begin
      if (!r_mask[i] && (w_cand[i] != r_pat[2*i +: 2])) begin
        w_fwd = 1'b0;
      end
      if (!r_mask[PAM_LEN-1-i] &&
          (w_cand[i] != ~r_pat[2*(PAM_LEN-1-i) +: 2])) begin
        w_rev = 1'b0;
      end
    end
  end

  assign w_push = w_accept && w_armed && (w_fwd || w_rev);
  assign w_rec  = {w_fwd, w_rev, r_pos - LP_K0};

  // Control FSM, shadow configuration, window and hit counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_mask  <= '0;
      r_len   <= '0;
      r_rc    <= 1'b0;
      r_pos   <= '0;
      r_mc    <= '0;
      for (int i = 0; i < PAM_LEN; i++) begin
        r_win[i] <= 2'b00;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_pat  <= cfg_pattern;
            r_mask <= cfg_mask;
            r_len  <= cfg_seq_len;
            r_rc   <= cfg_rc_en;
            r_pos  <= '0;
            r_mc   <= '0;
            for (int i = 0; i < PAM_LEN; i++) begin
              r_win[i] <= 2'b00;
            end
            // An empty scan never opens the input stream.
            r_state <= (cfg_seq_len == '0) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_accept) begin
            for (int i = 0; i < PAM_LEN - 1; i++) begin
              r_win[i] <= r_win[i+1];
            end
            r_win[PAM_LEN-1] <= in_base;
            r_pos <= r_pos + LP_POS_ONE;
            if (w_push && (r_mc != '1)) begin
              r_mc <= r_mc + LP_POS_ONE;
            end
            if (w_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result FIFO. The FIFO survives start and is cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_rec;
        r_wr        <= r_wr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd <= r_rd + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + LP_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - LP_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign res_data    = r_mem[r_rd];
  assign res_valid   = !w_empty;
  assign match_count = r_mc;
  assign busy        = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_pam_stream_scanner.sv
// Testbench for pam_stream_scanner (PAM_LEN=3, POS_W=24, FIFO_DEPTH=8).
// It runs directed vector scans, hand-written back-pressure and reset
// sequences, and randomized scans. The randomized scans are checked against
// a string-level motif model.
module tb_pam_stream_scanner;

  localparam int PL = 3;
  localparam int PW = 24;
  localparam int FD = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [2*PL-1:0] cfg_pattern;
  logic [PL-1:0]   cfg_mask;
  logic [PW-1:0]   cfg_seq_len;
  logic            cfg_rc_en;
  logic            start;
  logic [1:0]      in_base;
  logic            in_valid;
  logic            in_ready;
  logic [PW+1:0]   res_data;
  logic            res_valid;
  logic            res_ready;
  logic [PW-1:0]   match_count;
  logic            busy;
  logic            done;

  always #5 clock = ~clock;

  pam_stream_scanner #(.PAM_LEN(PL), .POS_W(PW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_seq_len(cfg_seq_len), .cfg_rc_en(cfg_rc_en),
    .start(start), .in_base(in_base), .in_valid(in_valid),
    .in_ready(in_ready), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .match_count(match_count),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [2*PL-1:0] pat;
    logic [PL-1:0]   msk;
    logic            rc;
    int              len;
    logic [31:0]     bases;   // base j at [2j+1:2j]
    int              nexp;
    logic [PW+1:0]   e0;
    logic [PW+1:0]   e1;
  } vec_t;

  logic [1:0]    stim[$];
  logic [PW+1:0] got[$];
  logic [PW+1:0] exp_q[$];
  int            idx;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference model: slide a PL-base window over the stimulus string and
  // compare it against the pattern and its reverse complement. The reverse
  // complement is built by reversing the pattern and mapping each code x to 3-x.
  function automatic void model(input logic [2*PL-1:0] pat, input logic [PL-1:0] msk,
                                input bit rc, input int len);
    int fp[PL];
    int rp[PL];
    bit fm[PL];
    bit rm[PL];
    exp_q.delete();
    for (int i = 0; i < PL; i++) begin
      fp[i] = int'(pat[2*i +: 2]);
      fm[i] = msk[i];
    end
    for (int i = 0; i < PL; i++) begin
      rp[i] = 3 - fp[PL-1-i];
      rm[i] = fm[PL-1-i];
    end
    for (int p = 0; p + PL <= len; p++) begin
      bit f;
      bit r;
      f = 1'b1;
      r = rc;
      for (int i = 0; i < PL; i++) begin
        if (!fm[i] && int'(stim[p+i]) != fp[i]) f = 1'b0;
        if (!rm[i] && int'(stim[p+i]) != rp[i]) r = 1'b0;
      end
      if (f || r) exp_q.push_back({f, r, 24'(p)});
    end
  endfunction

  task automatic start_scan(input logic [2*PL-1:0] pat, input logic [PL-1:0] msk,
                            input logic rc, input int len);
    @(negedge clock);
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_rc_en   = rc;
    cfg_seq_len = PW'(len);
    start       = 1'b1;
    in_valid    = 1'b0;
    res_ready   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    got.delete();
    idx = 0;
  endtask

  // One handshake step per cycle. Inputs change at the falling edge. Each
  // transfer is recorded from values that are stable into the next rising edge.
  task automatic drive(input int n, input int vp, input int rp,
                       input bit until_done, output bit timed_out);
    for (int c = 0; c < n; c++) begin
      if (until_done && done) break;
      in_valid  = (idx < stim.size()) && ($urandom_range(0, 99) < vp);
      in_base   = in_valid ? stim[idx] : 2'b00;
      res_ready = ($urandom_range(0, 99) < rp);
      if (in_valid && in_ready) idx++;
      if (res_valid && res_ready) got.push_back(res_data);
      @(posedge clock);
      @(negedge clock);
    end
    timed_out = until_done && !done;
    in_valid  = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic compare_scan(input string tag);
    chk({tag, ".rec_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.rec%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk({tag, ".match_count"}, match_count, exp_q.size());
    chk({tag, ".done"}, done, 1);
    chk({tag, ".res_valid"}, res_valid, 0);
  endtask

  task automatic load_stim(input logic [31:0] bases, input int len);
    stim.delete();
    for (int j = 0; j < len; j++) stim.push_back(bases[2*j +: 2]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    bit   to;
    logic [1:0] rb;

    tbl[0] = '{6'h28, 3'b001, 1'b1, 8, 32'h17A4, 2, {2'b10, 24'd1}, {2'b01, 24'd5}}; // NGG on ACGGTCCA
    tbl[1] = '{6'h28, 3'b001, 1'b0, 8, 32'h17A4, 1, {2'b10, 24'd1}, '0};             // forward only
    tbl[2] = '{6'h30, 3'b010, 1'b1, 3, 32'h34,   1, {2'b11, 24'd0}, '0};             // ANT palindrome on ACT
    tbl[3] = '{6'h00, 3'b111, 1'b0, 4, 32'h1B,   2, {2'b10, 24'd0}, {2'b10, 24'd1}}; // all masked

    reset = 1'b1;
    cfg_pattern = '0; cfg_mask = '0; cfg_seq_len = '0; cfg_rc_en = 1'b0;
    start = 1'b0; in_base = 2'b00; in_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_data", 32'(res_data), 0);
    chk("rst.match_count", match_count, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    reset = 1'b0;

    // Directed vectors
    for (int t = 0; t < 4; t++) begin
      load_stim(tbl[t].bases, tbl[t].len);
      start_scan(tbl[t].pat, tbl[t].msk, tbl[t].rc, tbl[t].len);
      drive(200, 100, 100, 1'b1, to);
      chk($sformatf("vec%0d.timeout", t), 32'(to), 0);
      chk($sformatf("vec%0d.rec_count", t), got.size(), tbl[t].nexp);
      if (got.size() > 0) chk($sformatf("vec%0d.rec0", t), 32'(got[0]), 32'(tbl[t].e0));
      if (got.size() > 1) chk($sformatf("vec%0d.rec1", t), 32'(got[1]), 32'(tbl[t].e1));
      chk($sformatf("vec%0d.match_count", t), match_count, tbl[t].nexp);
      chk($sformatf("vec%0d.done", t), done, 1);
    end

    // seq_len = 0: straight to DONE, input stream never opens
    stim.delete();
    start_scan(6'h28, 3'b001, 1'b1, 0);
    chk("len0.done", done, 1);
    chk("len0.busy", busy, 0);
    chk("len0.in_ready", in_ready, 0);
    chk("len0.match_count", match_count, 0);
    chk("len0.res_valid", res_valid, 0);

    // Back-pressure: 12 G bases, FIFO never popped until it fills
    load_stim(32'h00AA_AAAA, 12);
    start_scan(6'h28, 3'b001, 1'b0, 12);
    drive(20, 100, 0, 1'b0, to);
    chk("bp.accepted", idx, 10);
    chk("bp.in_ready", in_ready, 0);
    chk("bp.res_valid", res_valid, 1);
    chk("bp.match_count", match_count, 8);
    chk("bp.busy", busy, 1);
    chk("bp.head", 32'(res_data), 32'({2'b10, 24'd0}));
    drive(300, 100, 100, 1'b1, to);
    chk("bp.timeout", 32'(to), 0);
    model(6'h28, 3'b001, 1'b0, 12);
    compare_scan("bp");

    // Reset in the middle of a scan with three hits queued
    load_stim(32'h00AA_AAAA, 12);
    start_scan(6'h28, 3'b001, 1'b0, 12);
    drive(5, 100, 0, 1'b0, to);
    chk("abort.pre_match_count", match_count, 3);
    chk("abort.pre_res_valid", res_valid, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort.res_valid", res_valid, 0);
    chk("abort.busy", busy, 0);
    chk("abort.match_count", match_count, 0);
    chk("abort.in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    load_stim(32'h0017_A4A8, 11);
    start_scan(6'h28, 3'b001, 1'b1, 11);
    drive(400, 80, 60, 1'b1, to);
    chk("abort.rescan_timeout", 32'(to), 0);
    model(6'h28, 3'b001, 1'b1, 11);
    compare_scan("rescan");

    // Randomized scans against the model
    for (int it = 0; it < 25; it++) begin
      logic [2*PL-1:0] pat;
      logic [PL-1:0]   msk;
      logic            rc;
      int              len;
      pat = (2*PL)'($urandom);
      msk = PL'($urandom_range(0, 7));
      rc  = 1'($urandom);
      len = $urandom_range(0, 30);
      stim.delete();
      for (int j = 0; j < len; j++) begin
        rb = 2'($urandom_range(0, 3));
        stim.push_back(rb);
      end
      start_scan(pat, msk, rc, len);
      drive(2000, 70, 40, 1'b1, to);
      chk($sformatf("rand%0d.timeout", it), 32'(to), 0);
      model(pat, msk, rc, len);
      compare_scan($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pam_stream_scanner.md
Name: pam_stream_scanner

Overview:
Streaming PAM-motif detector that sits directly upstream of the PAMSearcher AXI4-Lite register block. It consumes 2-bit-encoded nucleotides and compares a sliding window against a programmable PAM pattern with a don't-care mask, on both forward and reverse-complement strands. Each hit is pushed as a position record into an internal FIFO, which the register block drains. The pattern, mask, sequence length and start come from the register block.

Parameters:
PAM_LEN, 3, window/pattern length in bases (2..8)
POS_W, 24, width of position counter and seq_len
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
cfg_pattern  in  2*PAM_LEN  base i at [2i+1:2i]; A=00 C=01 G=10 T=11
cfg_mask  in  PAM_LEN  bit i=1: base i is don't-care
cfg_seq_len  in  POS_W  number of bases to scan
cfg_rc_en  in  1  also search reverse-complement pattern
start  in  1  one-cycle pulse, begins a scan
in_base  in  2  nucleotide code
in_valid  in  1  base present
in_ready  out  1  base accepted when in_valid&&in_ready
res_data  out  POS_W+2  {fwd_hit, rev_hit, position}
res_valid  out  1  FIFO not empty
res_ready  in  1  pop when res_valid&&res_ready
match_count  out  POS_W  hits pushed this scan (saturating)
busy  out  1  state SCAN or DRAIN
done  out  1  state DONE

Behaviour:
- Reset values: in_ready=0, res_valid=0, res_data=0, match_count=0, busy=0, done=0; FSM=IDLE; window, position and FIFO pointers cleared.
- FSM IDLE/DONE --start--> SCAN. On entry: latch cfg_* into shadow registers, clear position, base count, window and match_count. Do not flush the FIFO.
- If the latched seq_len=0, go IDLE/DONE -> DONE on the next edge.
- SCAN: in_ready = !fifo_full. The FIFO reserves space for one more push every cycle, so no hit is ever dropped. When the seq_len-th base is accepted -> DRAIN.
- DRAIN: in_ready=0. When the FIFO is empty -> DONE.
- DONE: done=1, held until the next start.
- start is ignored in SCAN and DRAIN.
- Window: a shift register of the last PAM_LEN accepted bases. window[0] is the oldest. Each accept shifts in_base into the newest slot.
- Matching is combinational on {window[1..PAM_LEN-1], in_base} at the accepting edge, and is evaluated only when accepted-base index k >= PAM_LEN-1.
- fwd_hit: every unmasked base i equals pattern i.
- rev_hit (only if cfg_rc_en): RC pattern base i = ~pattern[PAM_LEN-1-i], RC mask bit i = mask[PAM_LEN-1-i]; match as for fwd.
- If fwd_hit||rev_hit: push {fwd_hit, rev_hit, k-(PAM_LEN-1)} on the same edge as the accept, and increment match_count (saturate at all-ones). A palindromic hit produces a single record with both bits set.
- All-masked pattern: every window position matches.
- res_valid rises on the edge after the push, i.e. 1-cycle latency from base accept to res_valid.
- res_data = FIFO head; it is registered/stable while res_valid && !res_ready.
- FIFO: simultaneous push and pop when full is legal in SCAN, but in_ready is already 0 when full, so no push occurs then. Push and pop in the same cycle when non-empty keep the occupancy constant.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-scan aborts immediately. The FIFO is emptied, and contents are not recovered.

Test Plan:
1. PAM_LEN=3, pattern=6'h28 (NGG), mask=3'b001, rc_en=1, seq_len=8, stream ACGGTCCA, res_ready=1 -> records {1,0,1} then {0,1,5}; match_count=2; done=1 after the FIFO empties.
2. Same setup, rc_en=0 -> single record {1,0,1}; match_count=1.
3. Stream GGGGGGGGGGGG (12 bases), NGG fwd only, res_ready=0, FIFO_DEPTH=8 -> 8 hits (pos 0..7), then in_ready=0 and no drops. Then raise res_ready -> positions 0..9 in order; match_count=10; done asserted.
4. seq_len=0 with start -> DONE one cycle later; no records; in_ready never 1.
5. Pattern CCG/GG-style palindrome: pattern 6'b10_01_01? Use pattern 6'h16 (G,C,C reversed->GGC?); choose pattern ACGT-style PAM_LEN=4 pattern 8'hE4 (ACGT), mask=0, rc_en=1, stream ACGT -> one record {1,1,0}.
6. Assert reset during SCAN after 3 hits are queued -> res_valid=0, busy=0, match_count=0 on the same cycle. A fresh start then rescans correctly.
